// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared constants, FSM state type and frame builder for the DAC SPI transmitter
//
// Contents:
//   FRAME_W      : command frame width on the serial bus
//   BITCNT_W     : width of the frame bit counter (0..31)
//   DAC_CMD_*    : command field encodings (write-and-update, power-down)
//   DAC_ADDR_ALL : address field selecting every DAC channel
//   dac_state_e  : transmitter FSM states
//   dac_frame()  : assembles the 32-bit command word from its fields

package dac_pkg;

    localparam int FRAME_W  = 32;
    localparam int BITCNT_W = 5;

    localparam logic [3:0] DAC_CMD_WRITE_UPDATE = 4'h3;
    localparam logic [3:0] DAC_CMD_POWER_DOWN   = 4'h4;
    localparam logic [3:0] DAC_ADDR_ALL         = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_FIN
    } dac_state_e;

    // Frame layout, MSB sent first: 8 don't-care zeros, command, address,
    // 12-bit sample, 4 trailing zeros.
    function automatic logic [FRAME_W-1:0] dac_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  addr,
        input logic [11:0] sample
    );
        return {8'h00, cmd, addr, sample, 4'h0};
    endfunction

endpackage

// File: rtl/dac_sck_gen.sv
// rtl/dac_sck_gen.sv - half-period counter producing sck and rise/fall tick strobes
//
// Ports:
//   clock     : system clock
//   reset_n   : asynchronous active-low reset
//   clear     : synchronous hold-in-reset while the transmitter is idle
//   enable    : counter runs while a frame is being shifted
//   sck       : serial clock, idle low
//   rise_tick : one-cycle strobe in the last low cycle; sck rises on the next edge
//   fall_tick : one-cycle strobe in the last high cycle; sck falls on the next edge

module dac_sck_gen #(
    parameter int HALF_PER = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic sck,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int              CNT_W    = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PER - 1);

    logic [CNT_W-1:0] cnt;
    logic             half_end;

    assign half_end  = enable && (cnt == CNT_LAST);
    assign rise_tick = half_end && !sck;
    assign fall_tick = half_end && sck;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (enable) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
                sck <= ~sck;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - SPI transmitter writing 12-bit samples to an LTC2624-class quad DAC
//
// Optional feature macro: DAC_READBACK_EN (adds dac_miso capture and readback port)
//
// Ports:
//   clock       : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   clockenable : one-cycle sample strobe; starts a frame when idle
//   datos[11:0] : sample, latched in the accept cycle
//   mosi        : serial data to the DAC, MSB first
//   sck         : serial clock, idle low
//   cs_n        : DAC chip-select, active low
//   busy        : frame in progress
//   done        : one-cycle pulse in the cycle after the frame ends
//   dac_miso    : DAC echo data (DAC_READBACK_EN only)
//   readback    : previous frame as echoed by the DAC (DAC_READBACK_EN only)

import dac_pkg::*;

module dac_spi_tx #(
    parameter int         HALF_PER  = 2,
    parameter logic [3:0] DAC_ADDR  = DAC_ADDR_ALL,
    parameter logic [3:0] DAC_CMD   = DAC_CMD_WRITE_UPDATE,
    parameter bit         SIGNED_IN = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                clockenable,
    input  logic [11:0]         datos,
    output logic                mosi,
    output logic                sck,
    output logic                cs_n,
    output logic                busy,
    output logic                done
`ifdef DAC_READBACK_EN
    ,
    input  logic                dac_miso,
    output logic [FRAME_W-1:0]  readback
`endif
);

    dac_state_e           state;
    dac_state_e           state_nx;
    logic [FRAME_W-1:0]   shreg;
    logic [BITCNT_W-1:0]  bit_cnt;
    logic [11:0]          sample;
    logic                 accept;
    logic                 last_bit;
    logic                 gen_clear;
    logic                 gen_enable;
    logic                 rise_tick;
    logic                 fall_tick;
    logic                 frame_end;

    // Two's complement to offset binary is a flip of the sign bit.
    assign sample    = SIGNED_IN ? {~datos[11], datos[10:0]} : datos;
    assign accept    = (state == ST_IDLE) && clockenable;
    assign last_bit  = (bit_cnt == BITCNT_W'(FRAME_W - 1));
    assign frame_end = (state == ST_HIGH) && fall_tick && last_bit;

    dac_sck_gen #(
        .HALF_PER (HALF_PER)
    ) u_sck_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (gen_clear),
        .enable    (gen_enable),
        .sck       (sck),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Outputs decode straight from the state register so an asynchronous
    // reset drops cs_n and busy in the same instant.
    always_comb begin
        state_nx   = state;
        cs_n       = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        gen_clear  = 1'b0;
        gen_enable = 1'b0;
        case (state)
            ST_IDLE: begin
                gen_clear = 1'b1;
                if (clockenable) begin
                    state_nx = ST_LOW;
                end
            end
            ST_LOW: begin
                cs_n       = 1'b0;
                busy       = 1'b1;
                gen_enable = 1'b1;
                if (rise_tick) begin
                    state_nx = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cs_n       = 1'b0;
                busy       = 1'b1;
                gen_enable = 1'b1;
                if (fall_tick) begin
                    state_nx = last_bit ? ST_FIN : ST_LOW;
                end
            end
            ST_FIN: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Shift only on falling sck so mosi never moves while sck is high. The
    // last falling edge clears the register instead, leaving mosi low idle;
    // the counter stops at 31 and never starts a 33rd bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            shreg   <= dac_frame(DAC_CMD, DAC_ADDR, sample);
            bit_cnt <= '0;
        end else if ((state == ST_HIGH) && fall_tick) begin
            if (last_bit) begin
                shreg <= '0;
            end else begin
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    assign mosi = shreg[FRAME_W-1];

`ifdef DAC_READBACK_EN
    logic [FRAME_W-1:0] rx_sh;

    // rise_tick marks the edge on which sck goes high, which is the DAC's
    // sampling edge; the echo is captured on that same edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_sh    <= '0;
            readback <= '0;
        end else begin
            if (rise_tick) begin
                rx_sh <= {rx_sh[FRAME_W-2:0], dac_miso};
            end
            if (frame_end) begin
                readback <= rx_sh;
            end
        end
    end
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end;
`endif

endmodule
